// File: rtl/mem_cmd_initiator.sv
// mem_cmd_initiator: queues read/write commands and runs them one at a time on the mem bus, returning one response each.
module mem_cmd_initiator #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int CMD_DEPTH  = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_rwn,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_rwn,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  cs,
  output logic                  rwn,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rdy,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy
);
  localparam int PW = $clog2(CMD_DEPTH);
  localparam int TW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_n;
  logic [DATA_WIDTH+ADDR_WIDTH:0] mem [CMD_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count;
  logic [TW-1:0] timer;
  logic rwn_q, push, launch, hit, expire;
  assign cmd_ready = count != (PW+1)'(CMD_DEPTH);
  assign push      = cmd_valid & cmd_ready;
  assign busy      = count != '0 || state != IDLE;
  assign cs        = state == ACCESS;
  assign rwn       = cs ? rwn_q : 1'b1;
  assign rsp_valid = state == RESP;
  always_comb begin
    launch  = state == IDLE && count != '0;
    hit     = cs && rdy;
    expire  = cs && !rdy && TIMEOUT != 0 && timer == TW'(TIMEOUT - 1);
    state_n = launch ? ACCESS : (hit || expire) ? RESP : (rsp_valid && rsp_ready) ? IDLE : state;
  end
  always_ff @(posedge clock)
    if (push) mem[wr_ptr] <= {cmd_rwn, cmd_addr, cmd_wdata};
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      timer     <= '0;
      rwn_q     <= 1'b1;
      addr      <= '0;
      wdata     <= '0;
      rsp_rwn   <= 1'b1;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state  <= state_n;
      count  <= count + (PW+1)'(push) - (PW+1)'(launch);
      timer  <= launch ? '0 : cs ? timer + 1'b1 : timer;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (launch) begin
        rd_ptr                <= rd_ptr + 1'b1;
        {rwn_q, addr, wdata}  <= mem[rd_ptr];
      end
      // a late rdy coinciding with expiry wins, since hit masks expire
      if (hit || expire) begin
        rsp_rwn   <= rwn_q;
        rsp_rdata <= hit && rwn_q ? rdata : '0;
        rsp_err   <= expire;
      end
    end
endmodule

// File: tb/tb_mem_cmd_initiator.sv
// tb_mem_cmd_initiator: table vectors, corner sequences and random traffic checked against a response model.
module tb_mem_cmd_initiator;
  localparam int TO = 16;
  logic clock = 1'b0, reset = 1'b0;
  logic cmd_valid = 1'b0, cmd_rwn = 1'b0, rsp_ready = 1'b0, rdy = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0, rdata = '0;
  logic cmd_ready, rsp_valid, rsp_rwn, rsp_err, cs, rwn, busy;
  logic [31:0] rsp_rdata, wdata;
  logic [15:0] addr;

  mem_cmd_initiator #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .CMD_DEPTH(4), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rwn(cmd_rwn),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rwn(rsp_rwn), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .cs(cs), .rwn(rwn), .addr(addr),
    .wdata(wdata), .rdy(rdy), .rdata(rdata), .busy(busy));

  always #5 clock = ~clock;

  typedef struct {
    logic rwn; logic [15:0] addr; logic [31:0] wdata; logic [31:0] rd; int delay;
    logic err; logic [31:0] rdata; int cslen;
  } rec_t;

  rec_t pq[$];
  rec_t nrec, tbl[8];
  int tests = 0, fails = 0, cyc = 0, cs_len = 0, low_len = 2;
  logic noise = 1'b0, pushed = 1'b0, cs_prev = 1'b0, hold_prev = 1'b0;
  logic [48:0] bsnap;
  logic [33:0] rsnap;

  // response rules: rdy in cs cycle 1..TO succeeds, anything else (0 = never) times out after TO cycles
  function automatic rec_t mk(logic r, logic [15:0] a, logic [31:0] wd, logic [31:0] rd, int dl);
    rec_t x;
    bit ok = dl >= 1 && dl <= TO;
    x = '{r, a, wd, rd, dl, !ok, (r && ok) ? rd : 32'h0, ok ? dl : TO};
    return x;
  endfunction

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic bad(input string n);
    tests++;
    fails++;
    $display("FAIL %s: event with no matching command", n);
  endtask

  // bus responder: rdy in the delay-th cycle of cs, random noise on rdy while cs is low
  always @(negedge clock) begin
    if (!cs) begin
      cyc = 0;
      rdy = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      rdata = $urandom;
    end else begin
      cyc++;
      rdy = pq.size() > 0 ? cyc == pq[0].delay : 1'b1;
      rdata = (rdy && pq.size() > 0) ? pq[0].rd : $urandom;
    end
  end

  task automatic tick();
    rec_t r;
    pushed = cmd_valid && cmd_ready;
    if (pushed) pq.push_back(nrec);
    hold_prev = rsp_valid && !rsp_ready;
    rsnap = {rsp_rwn, rsp_err, rsp_rdata};
    if (rsp_valid && rsp_ready) begin
      if (pq.size() == 0) bad("rsp_extra");
      else begin
        r = pq.pop_front();
        chk("rsp_rwn", 64'(rsp_rwn), 64'(r.rwn));
        chk("rsp_err", 64'(rsp_err), 64'(r.err));
        chk("rsp_rdata", 64'(rsp_rdata), 64'(r.rdata));
      end
    end
    @(negedge clock);
    if (cs && rsp_valid) chk("cs_during_rsp", 64'(cs), 64'(0));
    if (hold_prev) chk("rsp_hold", 64'({rsp_valid, rsp_rwn, rsp_err, rsp_rdata}), 64'({1'b1, rsnap}));
    if (cs && !cs_prev) begin
      chk("cs_gap", 64'(low_len >= 2), 64'(1));
      if (pq.size() == 0) bad("cs_nocmd");
      else begin
        chk("bus_rwn", 64'(rwn), 64'(pq[0].rwn));
        chk("bus_addr", 64'(addr), 64'(pq[0].addr));
        if (!pq[0].rwn) chk("bus_wdata", 64'(wdata), 64'(pq[0].wdata));
      end
      bsnap = {rwn, addr, wdata};
      cs_len = 1;
    end else if (cs) begin
      if ({rwn, addr, wdata} !== bsnap) chk("bus_stable", 64'({rwn, addr, wdata}), 64'(bsnap));
      cs_len++;
    end else if (cs_prev) begin
      if (pq.size() == 0) bad("cs_len");
      else chk("cs_len", 64'(cs_len), 64'(pq[0].cslen));
      chk("rwn_idle", 64'(rwn), 64'(1));
      low_len = 1;
    end else low_len++;
    cs_prev = cs;
  endtask

  task automatic send(input rec_t r);
    nrec = r;
    cmd_valid = 1'b1;
    cmd_rwn = r.rwn;
    cmd_addr = r.addr;
    cmd_wdata = r.wdata;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (pushed) break;
    end
    if (!pushed) chk("push_timeout", 64'(pushed), 64'(1));
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (pq.size() == 0 && !busy) break;
      tick();
    end
    chk("drain", 64'(pq.size()), 64'(0));
    chk("busy_end", 64'(busy), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b0, 16'h0010, 32'hDEADBEEF, 32'h0,        3,  1'b0, 32'h0,        3};
    tbl[1] = '{1'b1, 16'h0020, 32'h0,        32'h12345678, 1,  1'b0, 32'h12345678, 1};
    tbl[2] = '{1'b1, 16'h0030, 32'h0,        32'h11111111, 0,  1'b1, 32'h0,        16};
    tbl[3] = '{1'b1, 16'h0040, 32'h0,        32'hCAFEF00D, 16, 1'b0, 32'hCAFEF00D, 16};
    tbl[4] = '{1'b0, 16'h0050, 32'h55AA55AA, 32'h22222222, 17, 1'b1, 32'h0,        16};
    tbl[5] = '{1'b1, 16'hFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 2,  1'b0, 32'hFFFFFFFF, 2};
    tbl[6] = '{1'b0, 16'h0000, 32'h0,        32'h33333333, 16, 1'b0, 32'h0,        16};
    tbl[7] = '{1'b1, 16'h0070, 32'h0,        32'h44444444, 20, 1'b1, 32'h0,        16};
    repeat (3) @(negedge clock);
    chk("reset_bus", 64'({cs, rwn, addr, wdata}), 64'({1'b0, 1'b1, 16'h0, 32'h0}));
    chk("reset_rsp", 64'({rsp_valid, rsp_rwn, rsp_err, rsp_rdata}), 64'({1'b0, 1'b1, 1'b0, 32'h0}));
    chk("reset_flags", 64'({busy, cmd_ready}), 64'({1'b0, 1'b1}));
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rsp_ready = 1'b1;
      send(tbl[i]);
      drain();
    end
    // five back-to-back commands: one launches, four fill the FIFO
    for (int k = 0; k < 5; k++) send(mk(1'(k), 16'(16'h0100 + k), $urandom, $urandom, 10));
    chk("full_ready", 64'(cmd_ready), 64'(0));
    chk("full_busy", 64'(busy), 64'(1));
    nrec = mk(1'b1, 16'h0199, 32'h0, 32'h0, 1);
    cmd_valid = 1'b1;
    tick();
    chk("full_nopush", 64'(pushed), 64'(0));
    cmd_valid = 1'b0;
    drain();
    chk("ready_after", 64'(cmd_ready), 64'(1));
    // response backpressure with a second command waiting
    rsp_ready = 1'b0;
    send(mk(1'b1, 16'h0300, 32'h0, 32'hABCD0001, 2));
    send(mk(1'b0, 16'h0304, 32'h87654321, 32'h0, 1));
    repeat (12) tick();
    chk("bp_rsp_valid", 64'(rsp_valid), 64'(1));
    chk("bp_cs", 64'(cs), 64'(0));
    chk("bp_queued", 64'(pq.size()), 64'(2));
    drain();
    // reset in the middle of an access with three more queued
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) send(mk(1'b1, 16'(16'h0200 + k), 32'h0, $urandom, 0));
    chk("pre_reset_cs", 64'(cs), 64'(1));
    #2 reset = 1'b0;
    #1;
    chk("async_cs", 64'(cs), 64'(0));
    chk("async_flags", 64'({busy, rsp_valid, cmd_ready}), 64'({1'b0, 1'b0, 1'b1}));
    @(negedge clock);
    reset = 1'b1;
    pq.delete();
    cs_prev = 1'b0;
    low_len = 2;
    hold_prev = 1'b0;
    repeat (5) tick();
    chk("post_reset", 64'({rsp_valid, busy, cmd_ready}), 64'({1'b0, 1'b0, 1'b1}));
    send(mk(1'b1, 16'h0400, 32'h0, 32'hA5A55A5A, 2));
    drain();
    // random traffic with rdy noise while cs is low
    noise = 1'b1;
    pushed = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!cmd_valid || pushed) begin
        cmd_valid = $urandom_range(0, 2) == 0;
        nrec = mk(1'($urandom_range(0, 1)), 16'($urandom), $urandom, $urandom, int'($urandom_range(0, 19)));
        cmd_rwn = nrec.rwn;
        cmd_addr = nrec.addr;
        cmd_wdata = nrec.wdata;
      end
      rsp_ready = $urandom_range(0, 3) != 0;
      tick();
    end
    cmd_valid = 1'b0;
    drain();
    noise = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_cmd_initiator.md
Name: mem_cmd_initiator

Overview:
- Bus-master stage that sits directly upstream of the mem bus interface and drives its initiator side (cs, rwn, addr, wdata; samples rdy, rdata).
- Accepts read/write commands on a valid/ready stream, buffers them in a small FIFO and executes them one at a time on the mem bus.
- Returns one response per command (read data or write acknowledge) on a valid/ready stream, with a timeout error when rdy never arrives.

Parameters:
- DATA_WIDTH, 32, width of wdata/rdata and the command/response data fields.
- ADDR_WIDTH, 16, width of addr and cmd_addr.
- CMD_DEPTH, 4, command FIFO entries; power of 2, at least 2.
- TIMEOUT, 16, rdy-sampling edges allowed per access before error; 0 disables the timeout.

Ports:
- clock  in  1  single clock; all logic rises on posedge.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command FIFO not full.
- cmd_rwn  in  1  1=read, 0=write.
- cmd_addr  in  ADDR_WIDTH  access address.
- cmd_wdata  in  DATA_WIDTH  write data; ignored for reads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rwn  out  1  echo of the command's rwn.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors.
- rsp_err  out  1  access timed out.
- cs  out  1  mem bus chip select.
- rwn  out  1  mem bus read/write_n.
- addr  out  ADDR_WIDTH  mem bus address.
- wdata  out  DATA_WIDTH  mem bus write data.
- rdy  in  1  mem bus access complete.
- rdata  in  DATA_WIDTH  mem bus read data; valid when cs=1, rwn=1 and rdy=1.
- busy  out  1  FIFO non-empty or state not IDLE.

Behaviour:
- Reset (reset=0, takes effect asynchronously):
  - FIFO emptied; state=IDLE; timer=0.
  - Outputs: cs=0, rwn=1, addr=0, wdata=0, rsp_valid=0, rsp_rwn=1, rsp_rdata=0, rsp_err=0, busy=0.
  - cmd_ready=1 once FIFO empty.
- cmd_ready = !fifo_full (combinational).
  - Push on cmd_valid & cmd_ready.
  - When full, no push even if a pop occurs on the same edge.
- FSM IDLE:
  - If FIFO non-empty and rsp_valid=0: pop the head and register cs=1, rwn, addr, wdata; timer=0; go to ACCESS.
  - Earliest launch is the edge after the push edge, so cs is high 1 cycle after the command handshake.
- FSM ACCESS:
  - cs, rwn, addr and wdata are held stable throughout.
  - On each edge with rdy=1: rsp_rdata = rwn ? rdata : 0; rsp_err=0; rsp_rwn=rwn; rsp_valid=1; cs=0; go to RESP.
  - Else, if TIMEOUT!=0 and timer==TIMEOUT-1: rsp_err=1; rsp_rdata=0; rsp_valid=1; cs=0; go to RESP.
  - Else timer++. Timer width is clog2(TIMEOUT+1).
  - rdy=1 on the same edge as timeout expiry counts as success.
- FSM RESP:
  - Hold all rsp_* stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_valid & rsp_ready: rsp_valid=0; go to IDLE.
  - cs is guaranteed low for at least 2 cycles between consecutive accesses.
- rdy while cs=0 is ignored.
- addr/wdata keep their last values after cs falls; rwn returns to 1.
- FIFO pointers are log2(CMD_DEPTH) bits and wrap modulo CMD_DEPTH; a count or extra pointer bit distinguishes full from empty.
- Commands complete strictly in order; exactly one response per accepted command.
- Reset mid-access: cs drops immediately; the in-flight command and queued commands are discarded; no response is produced.

Test Plan:
- Write addr=0x0010, wdata=0xDEADBEEF; responder asserts rdy on the 3rd cs cycle -> cs high 3 cycles with stable addr/wdata, rwn=0; then rsp_valid=1, rsp_rwn=0, rsp_err=0, rsp_rdata=0.
- Read addr=0x0020; responder returns rdata=0x12345678 with rdy on the 1st cs cycle -> rsp_rdata=0x12345678, rsp_err=0; cs high exactly 1 cycle.
- rdy held 0; push 5 commands -> 1 launches, 4 fill the FIFO, cmd_ready=0 on the 6th attempt. Release rdy -> 5 responses arrive in order with matching rsp_rwn, cmd_ready returns to 1, busy=0 at the end.
- TIMEOUT=16 with rdy held 0 -> cs high exactly 16 cycles, then rsp_err=1 and rsp_rdata=0. A following command whose rdy arrives in cycle 16 -> rsp_err=0.
- rsp_ready=0 for 10 cycles with 2 queued commands -> rsp_* held stable and second cs not asserted until the response handshake; then second access proceeds normally.
- Assert reset during ACCESS with 3 queued commands -> cs=0 immediately with no clock edge; after release: no rsp_valid, busy=0, cmd_ready=1; a new read completes correctly.
